// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset CPU: control FSM (top), shared datapath DP, unified 128-word RAM.
// Optional feature macro: MIPS_SRLV_EN enables srlv (funct 0x06); otherwise it is a no-op.
package mips_multicycle_core_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;
endpackage

module mips_ram (
  input  logic        clk,
  input  logic        i_we,
  input  logic [6:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  input  logic [6:0]  i_dbg_addr,
  output logic [31:0] o_dbg_data
);
  logic [31:0] mem_space [0:127];

  always_ff @(posedge clk) begin
    if (i_we) mem_space[i_addr] <= i_wdata;
  end

  assign o_rdata    = mem_space[i_addr];
  assign o_dbg_data = mem_space[i_dbg_addr];
endmodule

module mips_datapath
  import mips_multicycle_core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  state_t      i_state,
  input  logic [6:0]  i_sw_addr,
  output logic [31:0] o_pc,
  output logic [31:0] o_data,
  output logic [5:0]  o_op,
  output logic [5:0]  o_funct
);
  logic [31:0] r_pc, r_ir, r_a, r_b, r_aluout, r_mdr;
  logic [31:0] r_rf [0:31];

  logic [4:0]  w_rs, w_rt, w_rd, w_rf_waddr;
  logic [31:0] w_imm, w_rf_a, w_rf_b, w_alu, w_mem_rdata, w_rf_wdata;
  logic [6:0]  w_mem_addr;
  logic        w_mem_we, w_rf_we;

  assign w_rs   = r_ir[25:21];
  assign w_rt   = r_ir[20:16];
  assign w_rd   = r_ir[15:11];
  assign w_imm  = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_rf_a = (w_rs == 5'd0) ? '0 : r_rf[w_rs];
  assign w_rf_b = (w_rt == 5'd0) ? '0 : r_rf[w_rt];

  assign w_mem_addr = (i_state == S_FETCH) ? r_pc[6:0] : r_aluout[6:0];
  // Writes are gated by rst so a reset landing mid-instruction leaves memory/regs intact.
  assign w_mem_we   = (i_state == S_MEMWR) && !rst;

  mips_ram RAM (
    .clk        (clk),
    .i_we       (w_mem_we),
    .i_addr     (w_mem_addr),
    .i_wdata    (r_b),
    .o_rdata    (w_mem_rdata),
    .i_dbg_addr (i_sw_addr),
    .o_dbg_data (o_data)
  );

  always_comb begin
    w_alu = '0;
    case (r_ir[5:0])
      6'h20: w_alu = r_a + r_b;
      6'h22: w_alu = r_a - r_b;
      6'h24: w_alu = r_a & r_b;
      6'h25: w_alu = r_a | r_b;
      6'h2A: w_alu = {31'd0, $signed(r_a) < $signed(r_b)};
`ifdef MIPS_SRLV_EN
      6'h06: w_alu = r_b >> r_a[4:0];
`endif
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = w_rt;
    w_rf_wdata = r_aluout;
    case (i_state)
      S_MEMWB:  begin w_rf_we = 1'b1; w_rf_wdata = r_mdr; end
      S_ALUWB:  begin w_rf_we = 1'b1; w_rf_waddr = w_rd; end
      S_ADDIWB: w_rf_we = 1'b1;
      default:  w_rf_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && w_rf_we && (w_rf_waddr != 5'd0)) r_rf[w_rf_waddr] <= w_rf_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= '0;
    end else begin
      case (i_state)
        S_FETCH: begin
          r_ir <= w_mem_rdata;
          r_pc <= r_pc + 32'd1;
        end
        S_DECODE: begin
          r_a      <= w_rf_a;
          r_b      <= w_rf_b;
          r_aluout <= r_pc + w_imm;
        end
        S_MEMADR, S_ADDIEXEC: r_aluout <= r_a + w_imm;
        S_MEMRD:   r_mdr    <= w_mem_rdata;
        S_EXECUTE: r_aluout <= w_alu;
        S_BRANCH:  if (r_a == r_b) r_pc <= r_aluout;
        S_JUMP:    r_pc <= {r_pc[31:26], r_ir[25:0]};
        default: ;
      endcase
    end
  end

  assign o_pc    = r_pc;
  assign o_op    = r_ir[31:26];
  assign o_funct = r_ir[5:0];
endmodule

module mips_multicycle_core
  import mips_multicycle_core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  sw_addr,
  output logic [3:0]  state,
  output logic [31:0] pc,
  output logic [31:0] data
);
  state_t     r_state;
  logic [5:0] w_op, w_funct;
  logic       w_funct_ok;

  mips_datapath DP (
    .clk       (clk),
    .rst       (rst),
    .i_state   (r_state),
    .i_sw_addr (sw_addr),
    .o_pc      (pc),
    .o_data    (data),
    .o_op      (w_op),
    .o_funct   (w_funct)
  );

  // funct 0x06 always reaches EXECUTE; only its writeback depends on MIPS_SRLV_EN.
  assign w_funct_ok = (w_funct == 6'h20) || (w_funct == 6'h22) || (w_funct == 6'h24) ||
                      (w_funct == 6'h25) || (w_funct == 6'h2A) || (w_funct == 6'h06);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          case (w_op)
            6'h00:        r_state <= w_funct_ok ? S_EXECUTE : S_FETCH;
            6'h23, 6'h2B: r_state <= S_MEMADR;
            6'h04:        r_state <= S_BRANCH;
            6'h08:        r_state <= S_ADDIEXEC;
            6'h02:        r_state <= S_JUMP;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:   r_state <= (w_op == 6'h23) ? S_MEMRD : S_MEMWR;
        S_MEMRD:    r_state <= S_MEMWB;
`ifdef MIPS_SRLV_EN
        S_EXECUTE:  r_state <= S_ALUWB;
`else
        S_EXECUTE:  r_state <= (w_funct == 6'h06) ? S_FETCH : S_ALUWB;
`endif
        S_ADDIEXEC: r_state <= S_ADDIWB;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  assign state = r_state;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: reset, Fibonacci program, latencies, edge cases, reset mid-lw.
module tb_mips_multicycle_core;
  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  sw_addr;
  logic [3:0]  state;
  logic [31:0] pc;
  logic [31:0] data;

  int vectors = 0;
  int miscompares = 0;

  mips_multicycle_core dut (
    .clk     (clk),
    .rst     (rst),
    .sw_addr (sw_addr),
    .state   (state),
    .pc      (pc),
    .data    (data)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with state==FETCH; counts edges until FETCH is re-entered.
  task automatic measure(input int exp, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (state != 4'd0 && n < 12);
    chk(n, exp, tag);
  endtask

  logic [31:0] fib [0:20] = '{
    32'h20190040, 32'h00008020, 32'h20110001, 32'h8F37000F, 32'h20160001,
    32'h00007820, 32'h01F7402A, 32'h10080007, 32'h02119020, 32'hAF310001,
    32'hAF320002, 32'h8F300001, 32'h8F310002, 32'h01F67820, 32'h08000006,
    32'h02308022, 32'hAF300000, 32'h02309024, 32'h02309025, 32'h02D29006,
    32'h1000FFFF};
  int lat [0:14] = '{4, 4, 4, 5, 4, 4, 4, 3, 4, 4, 4, 5, 5, 4, 3};

  initial begin
    rst = 1'b1;
    sw_addr = '0;
    for (int i = 0; i < 21; i++) dut.DP.RAM.mem_space[i] = fib[i];
    dut.DP.RAM.mem_space[79] = 32'd5;

    // Reset held for 3 edges
    repeat (3) @(negedge clk);
    chk({28'd0, state}, 32'd0, "rst_state");
    chk(pc, 32'd0, "rst_pc");
    rst = 1'b0;
    @(negedge clk);
    chk({28'd0, state}, 32'd1, "first_decode_state");
    chk(pc, 32'd1, "first_fetch_pc");
    @(negedge clk);
    chk({28'd0, state}, 32'd9, "addi_decode_to_9");

    // Fibonacci run with per-instruction latency
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) measure(lat[i], $sformatf("latency_%0d", i));
    repeat (800) @(negedge clk);
    chk({31'd0, (pc == 32'd20) || (pc == 32'd21)}, 32'd1, "final_pc_20_21");
    chk({31'd0, (state == 4'd0) || (state == 4'd1) || (state == 4'd8)}, 32'd1, "final_loop_state");
    chk(dut.DP.RAM.mem_space[64], 32'd3, "mem64");
    chk(dut.DP.RAM.mem_space[65], 32'd5, "mem65");
    chk(dut.DP.RAM.mem_space[66], 32'd8, "mem66");
    chk(dut.DP.r_rf[16], 32'd3, "r16");
    chk(dut.DP.r_rf[17], 32'd8, "r17");
`ifdef MIPS_SRLV_EN
    chk(dut.DP.r_rf[18], 32'd5, "r18_srlv");
`else
    chk(dut.DP.r_rf[18], 32'd11, "r18_srlv_noop");
`endif
    sw_addr = 7'd66; #1;
    chk(data, 32'd8, "dbg_66");
    sw_addr = 7'd64; #1;
    chk(data, 32'd3, "dbg_64");
    sw_addr = 7'd65; #1;
    chk(data, 32'd5, "dbg_65");

    // Edge cases: add $0,$17,$17 ; addi $17,$17,-1 ; sub $9,$0,$22 ; lw $17,64($0)
    @(negedge clk);
    rst = 1'b1;
    dut.DP.RAM.mem_space[0] = 32'h02310020;
    dut.DP.RAM.mem_space[1] = 32'h2231FFFF;
    dut.DP.RAM.mem_space[2] = 32'h00164822;
    dut.DP.RAM.mem_space[3] = 32'h8C110040;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    measure(4, "add_r0_latency");
    chk({31'd0, dut.DP.r_rf[0] === 32'd16}, 32'd0, "r0_not_written");
    measure(4, "addi_neg_latency");
    chk(dut.DP.r_rf[17], 32'd7, "addi_decrement");
    measure(4, "sub_latency");
    chk(dut.DP.r_rf[9], 32'hFFFFFFFF, "sub_0_minus_1");
    for (int i = 0; i < 10 && state != 4'd3; i++) @(negedge clk);
    chk({28'd0, state}, 32'd3, "reach_memrd");
    rst = 1'b1;
    @(negedge clk);
    chk({28'd0, state}, 32'd0, "midlw_state");
    chk(pc, 32'd0, "midlw_pc");
    chk(dut.DP.r_rf[17], 32'd7, "midlw_no_write");
    @(negedge clk);
    chk(dut.DP.r_rf[17], 32'd7, "midlw_no_write_2");
    sw_addr = 7'd64; #1;
    chk(data, 32'd3, "mem_kept_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
